inst_fetch: RTL

//  Instruction fetch stage and IF/ID register. It sits directly upstream of the
//  16-bit instruction decoder. It owns the PC, issues one request at a time to

---
 rtl/inst_fetch_if.sv | 23 ++
 rtl/inst_fetch.sv | 106 ++++++++++
 2 files changed

// File: rtl/inst_fetch_if.sv
// inst_fetch_if: instruction-memory req/ack, redirect and decoder valid/ready signals
// for the fetch stage; master is the fetch stage, slave is the memory/decoder side.
interface inst_fetch_if #(parameter int PC_WIDTH = 8);
    logic                imem_req;
    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_ack;
    logic [15:0]         imem_rdata;
    logic                redirect;
    logic [PC_WIDTH-1:0] redirect_pc;
    logic                id_ready;
    logic                inst_valid;
    logic [15:0]         instruction;
    logic [PC_WIDTH-1:0] inst_pc;

    modport master (
        output imem_req, imem_addr, inst_valid, instruction, inst_pc,
        input  imem_ack, imem_rdata, redirect, redirect_pc, id_ready
    );
    modport slave (
        input  imem_req, imem_addr, inst_valid, instruction, inst_pc,
        output imem_ack, imem_rdata, redirect, redirect_pc, id_ready
    );
endinterface

// File: rtl/inst_fetch.sv
// inst_fetch: PC owner, single-outstanding imem fetcher and IF/ID register with a
// one-entry hold buffer for decoder back-pressure and redirect flushing.
module inst_fetch #(
    parameter int                  PC_WIDTH    = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter logic [15:0]         BUBBLE_INST = 16'hF000
) (
    input logic          clk,
    input logic          rst_n,
    inst_fetch_if.master bus
);
    typedef enum logic [1:0] {START, FETCH, HOLD, FLUSH} state_t;

    state_t              r_state, w_state;
    logic [PC_WIDTH-1:0] r_pc, w_pc, r_inst_pc, w_inst_pc, r_hold_pc, w_hold_pc;
    logic [PC_WIDTH-1:0] r_flush_addr, w_flush_addr;
    logic [15:0]         r_inst, w_inst, r_hold_inst, w_hold_inst;
    logic                r_valid, w_valid, w_free;

    assign w_free           = !r_valid || bus.id_ready;
    assign bus.imem_req     = (r_state == FETCH) || (r_state == FLUSH);
    // FLUSH keeps presenting the aborted address until memory completes it
    assign bus.imem_addr    = (r_state == FLUSH) ? r_flush_addr : r_pc;
    assign bus.inst_valid   = r_valid;
    assign bus.instruction  = r_inst;
    assign bus.inst_pc      = r_inst_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= START;
            r_pc         <= RESET_PC;
            r_valid      <= 1'b0;
            r_inst       <= BUBBLE_INST;
            r_inst_pc    <= '0;
            r_hold_inst  <= BUBBLE_INST;
            r_hold_pc    <= '0;
            r_flush_addr <= '0;
        end else begin
            r_state      <= w_state;
            r_pc         <= w_pc;
            r_valid      <= w_valid;
            r_inst       <= w_inst;
            r_inst_pc    <= w_inst_pc;
            r_hold_inst  <= w_hold_inst;
            r_hold_pc    <= w_hold_pc;
            r_flush_addr <= w_flush_addr;
        end
    end

    always_comb begin
        w_state      = r_state;
        w_pc         = r_pc;
        w_valid      = r_valid;
        w_inst       = r_inst;
        w_inst_pc    = r_inst_pc;
        w_hold_inst  = r_hold_inst;
        w_hold_pc    = r_hold_pc;
        w_flush_addr = r_flush_addr;
        // a redirect kills whatever is presented; a same-cycle id_ready counts as consumed
        if (bus.redirect && r_state != START) begin
            w_valid = 1'b0;
            w_inst  = BUBBLE_INST;
        end
        unique case (r_state)
            START: begin
                w_state = FETCH;
                if (bus.redirect) w_pc = bus.redirect_pc;
            end
            FETCH: begin
                if (bus.redirect) begin
                    w_pc         = bus.redirect_pc;
                    w_flush_addr = r_pc;
                    w_state      = bus.imem_ack ? FETCH : FLUSH;
                end else if (bus.imem_ack && w_free) begin
                    w_inst    = bus.imem_rdata;
                    w_inst_pc = r_pc;
                    w_valid   = 1'b1;
                    w_pc      = r_pc + 1'b1;
                end else if (bus.imem_ack) begin
                    w_hold_inst = bus.imem_rdata;
                    w_hold_pc   = r_pc;
                    w_pc        = r_pc + 1'b1;
                    w_state     = HOLD;
                end else if (r_valid && bus.id_ready) begin
                    w_valid = 1'b0;
                    w_inst  = BUBBLE_INST;
                end
            end
            HOLD: begin
                if (bus.redirect) begin
                    w_pc    = bus.redirect_pc;
                    w_state = FETCH;
                end else if (bus.id_ready) begin
                    w_inst    = r_hold_inst;
                    w_inst_pc = r_hold_pc;
                    w_state   = FETCH;
                end
            end
            FLUSH: begin
                if (bus.redirect) w_pc = bus.redirect_pc;
                if (bus.imem_ack) w_state = FETCH;
            end
            default: w_state = START;
        endcase
    end
endmodule
